// File: rtl/blackjack_pkg.sv
// Shared types and constants for the blackjack card path: deck geometry,
// card record, arbiter FSM states and the deck-index to card mapping.
package blackjack_pkg;

   localparam logic [5:0] DECK_SIZE = 6'd52;
   localparam logic [5:0] RANKS     = 6'd13;

   typedef struct packed {
      logic [3:0] value;
      logic [1:0] symbol;
   } card_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DRAW  = 3'd1,
      ST_PROBE = 3'd2,
      ST_GRANT = 3'd3,
      ST_CLEAR = 3'd4
   } state_e;

   typedef enum logic {
      REQ_PLAYER = 1'b0,
      REQ_DEALER = 1'b1
   } req_e;

   // Suit is found by repeated subtraction of RANKS; the remainder is the rank.
   function automatic card_t idx_to_card(input logic [5:0] idx);
      card_t      c;
      logic [5:0] r;
      r        = idx;
      c.symbol = 2'd0;
      for (int unsigned s = 0; s < 3; s++) begin
         if (r >= RANKS) begin
            r        = r - RANKS;
            c.symbol = c.symbol + 2'd1;
         end
      end
      c.value = 4'(r + 6'd1);
      return c;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [15:0] q
);

   localparam logic [15:0] TAPS = 16'hB400;

   logic [15:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (en) begin
         q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? TAPS : '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= SEED;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/card_deck_arbiter.sv
// 52-card deck shared by player and dealer hands: round-robin arbitration,
// LFSR-seeded draw with linear probing over the dealt-card mask.
module card_deck_arbiter
   import blackjack_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       shuffle,
   input  logic       req_player,
   input  logic       req_dealer,
   output logic       gnt_player,
   output logic       gnt_dealer,
   output logic [3:0] card_value,
   output logic [1:0] card_symbol,
   output logic [5:0] cards_left,
   output logic       deck_empty,
   output logic       busy
);

   state_e                state_q, state_d;
   req_e                  owner_q, owner_d;
   req_e                  last_q, last_d;
   logic [5:0]            idx_q, idx_d;
   logic [DECK_SIZE-1:0]  used_q, used_d;
   logic [5:0]            left_q, left_d;
   card_t                 card_q, card_d;
   logic [5:0]            lfsr_lo;
   logic [9:0]            lfsr_unused;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk (clk),
      .rst (rst),
      .en  (1'b1),
      .q   ({lfsr_unused, lfsr_lo})
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      idx_d   = idx_q;
      used_d  = used_q;
      left_d  = left_q;
      card_d  = card_q;
      case (state_q)
         ST_IDLE: begin
            if (shuffle) begin
               state_d = ST_CLEAR;
            end else if ((req_player || req_dealer) && (left_q != '0)) begin
               if (req_player && req_dealer) begin
                  owner_d = (last_q == REQ_DEALER) ? REQ_PLAYER : REQ_DEALER;
               end else begin
                  owner_d = req_player ? REQ_PLAYER : REQ_DEALER;
               end
               last_d  = owner_d;
               state_d = ST_DRAW;
            end
         end
         ST_DRAW: begin
            idx_d   = (lfsr_lo >= DECK_SIZE) ? lfsr_lo - DECK_SIZE : lfsr_lo;
            state_d = ST_PROBE;
         end
         ST_PROBE: begin
            // A free slot always exists: IDLE refused to start on an empty deck.
            if (!used_q[idx_q]) begin
               used_d[idx_q] = 1'b1;
               card_d        = idx_to_card(idx_q);
               left_d        = left_q - 6'd1;
               state_d       = ST_GRANT;
            end else begin
               idx_d = (idx_q == DECK_SIZE - 6'd1) ? '0 : idx_q + 6'd1;
            end
         end
         ST_GRANT: begin
            state_d = ST_IDLE;
         end
         ST_CLEAR: begin
            used_d  = '0;
            left_d  = DECK_SIZE;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= REQ_PLAYER;
         last_q  <= REQ_DEALER;
         idx_q   <= '0;
         used_q  <= '0;
         left_q  <= DECK_SIZE;
         card_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         used_q  <= used_d;
         left_q  <= left_d;
         card_q  <= card_d;
      end
   end

   assign gnt_player  = (state_q == ST_GRANT) && (owner_q == REQ_PLAYER);
   assign gnt_dealer  = (state_q == ST_GRANT) && (owner_q == REQ_DEALER);
   assign card_value  = card_q.value;
   assign card_symbol = card_q.symbol;
   assign cards_left  = left_q;
   assign deck_empty  = (left_q == '0);
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_card_deck_arbiter.sv
// Bench for card_deck_arbiter: transaction-level deck model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_card_deck_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       shuffle = 1'b0;
   logic       req_player = 1'b0;
   logic       req_dealer = 1'b0;
   logic       gnt_player, gnt_dealer;
   logic [3:0] card_value;
   logic [1:0] card_symbol;
   logic [5:0] cards_left;
   logic       deck_empty, busy;

   int checks   = 0;
   int failures = 0;

   card_deck_arbiter #(.LFSR_SEED(16'hACE1)) dut (
      .clk         (clk),
      .rst         (rst),
      .shuffle     (shuffle),
      .req_player  (req_player),
      .req_dealer  (req_dealer),
      .gnt_player  (gnt_player),
      .gnt_dealer  (gnt_dealer),
      .card_value  (card_value),
      .card_symbol (card_symbol),
      .cards_left  (cards_left),
      .deck_empty  (deck_empty),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // ---------------- deck model ----------------
   // A request accepted in IDLE at cycle n is granted at n+3+k, where k is the
   // number of already-dealt cards met while walking upward from the LFSR pick.
   logic [15:0] m_lfsr;
   bit          m_used [52];
   int          m_left;
   bit          m_last_dealer;
   bit          m_pend_dealer;
   int          m_pend_idx;
   int          m_cnt;
   bit          m_in_grant, m_clear, m_valid = 1'b0;
   bit          e_busy, e_gp, e_gd;
   int          e_val, e_sym;

   function automatic logic [15:0] poly_step(input logic [15:0] s);
      logic [15:0] fb;
      fb = '0;
      // feedback into the exponents 16,14,13,11 of a right-shifting register
      if (s[0]) fb = (16'd1 << 15) | (16'd1 << 13) | (16'd1 << 12) | (16'd1 << 10);
      return (s >> 1) ^ fb;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_lfsr = 16'hACE1;
         foreach (m_used[i]) m_used[i] = 1'b0;
         m_left = 52; m_last_dealer = 1'b1; m_cnt = 0;
         m_in_grant = 1'b0; m_clear = 1'b0; m_valid = 1'b1;
         e_busy = 1'b0; e_gp = 1'b0; e_gd = 1'b0; e_val = 0; e_sym = 0;
      end else begin
         m_lfsr = poly_step(m_lfsr);
         e_gp = 1'b0; e_gd = 1'b0;
         if (m_clear) begin
            foreach (m_used[i]) m_used[i] = 1'b0;
            m_left = 52; m_clear = 1'b0; e_busy = 1'b0;
         end else if (m_in_grant) begin
            m_in_grant = 1'b0; e_busy = 1'b0;
         end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_in_grant = 1'b1;
               m_used[m_pend_idx] = 1'b1;
               m_left--;
               e_val = m_pend_idx % 13 + 1;
               e_sym = m_pend_idx / 13;
               if (m_pend_dealer) e_gd = 1'b1; else e_gp = 1'b1;
            end
         end else if (shuffle) begin
            m_clear = 1'b1; e_busy = 1'b1;
         end else if ((req_player || req_dealer) && m_left > 0) begin
            int start, k;
            if (req_player && req_dealer) m_pend_dealer = !m_last_dealer;
            else m_pend_dealer = req_dealer;
            m_last_dealer = m_pend_dealer;
            start = int'(m_lfsr[5:0]) % 52;
            k = 0;
            while (m_used[(start + k) % 52]) k++;
            m_pend_idx = (start + k) % 52;
            m_cnt = 2 + k;
            e_busy = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("busy",        busy,        e_busy);
         check("gnt_player",  gnt_player,  e_gp);
         check("gnt_dealer",  gnt_dealer,  e_gd);
         check("cards_left",  cards_left,  m_left);
         check("deck_empty",  deck_empty,  m_left == 0);
         check("card_value",  card_value,  e_val);
         check("card_symbol", card_symbol, e_sym);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req_player = 1'b0; req_dealer = 1'b0; shuffle = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic draw(input bit dealer, output int lat, output int val, output int sym);
      bit ok;
      ok = 1'b0; lat = 0; val = 0; sym = 0;
      if (dealer) req_dealer = 1'b1; else req_player = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (dealer ? gnt_dealer : gnt_player) begin
            lat = i; val = card_value; sym = card_symbol; ok = 1'b1;
            break;
         end
      end
      req_player = 1'b0; req_dealer = 1'b0;
      if (!ok) check("draw_timeout", 0, 1);
      @(negedge clk);
   endtask

   function automatic int card_idx(input int val, input int sym);
      return sym * 13 + val - 1;
   endfunction

   initial begin
      int lat, val, sym, bad, missing, nmissing;
      bit seen [52];

      // reset state, then full deck by the player
      do_reset();
      check("rst_busy",  busy, 0);
      check("rst_left",  cards_left, 52);
      check("rst_empty", deck_empty, 0);
      check("rst_value", card_value, 0);
      check("rst_sym",   card_symbol, 0);
      check("rst_gnt",   {gnt_player, gnt_dealer}, 0);
      foreach (seen[i]) seen[i] = 1'b0;
      for (int n = 0; n < 52; n++) begin
         draw(1'b0, lat, val, sym);
         if (n == 0) begin
            // first pick after seed 0xACE1 is index 48: ten of suit 3
            check("first_latency", lat, 3);
            check("first_value",   val, 10);
            check("first_symbol",  sym, 3);
         end
         check("lat_range", (lat >= 3 && lat <= 54), 1);
         check("card_range", (val >= 1 && val <= 13 && sym <= 3), 1);
         if (val >= 1 && val <= 13 && sym <= 3) begin
            check("card_unique", seen[card_idx(val, sym)], 0);
            seen[card_idx(val, sym)] = 1'b1;
         end
      end
      check("full_left",  cards_left, 0);
      check("full_empty", deck_empty, 1);
      bad = 0;
      req_player = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (gnt_player || busy) bad++;
      end
      req_player = 1'b0;
      check("empty_ignored", bad, 0);

      // shuffle on an empty deck
      shuffle = 1'b1;
      @(negedge clk);
      shuffle = 1'b0;
      check("shuffle_busy", busy, 1);
      @(negedge clk);
      check("shuffle_idle",  busy, 0);
      check("shuffle_left",  cards_left, 52);
      check("shuffle_empty", deck_empty, 0);
      draw(1'b0, lat, val, sym);
      check("post_shuffle_lat", (lat >= 3 && lat <= 54), 1);

      // both requesting: strict alternation starting with player
      do_reset();
      req_player = 1'b1; req_dealer = 1'b1;
      for (int g = 0; g < 6; g++) begin
         bit got;
         got = 1'b0;
         for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (gnt_player || gnt_dealer) got = 1'b1;
         end
         check("tie_timeout", got, 1);
         check("tie_order", {gnt_player, gnt_dealer}, (g % 2 == 0) ? 2'b10 : 2'b01);
         check("tie_left", cards_left, 51 - g);
      end
      req_player = 1'b0; req_dealer = 1'b0;
      @(negedge clk);
      check("tie_final_left", cards_left, 46);

      // last card of the deck
      do_reset();
      foreach (seen[i]) seen[i] = 1'b0;
      for (int n = 0; n < 51; n++) begin
         draw(n % 3 == 0, lat, val, sym);
         if (val >= 1 && val <= 13 && sym <= 3) seen[card_idx(val, sym)] = 1'b1;
      end
      check("left_one", cards_left, 1);
      nmissing = 0; missing = -1;
      foreach (seen[i]) if (!seen[i]) begin nmissing++; missing = i; end
      check("one_missing", nmissing, 1);
      draw(1'b1, lat, val, sym);
      check("last_lat", (lat >= 3 && lat <= 54), 1);
      check("last_idx", card_idx(val, sym), missing);
      check("last_empty", deck_empty, 1);

      // reset while probing loses the grant
      do_reset();
      req_player = 1'b1;
      @(negedge clk);
      check("probe_draw_busy", busy, 1);
      @(negedge clk);
      rst = 1'b1; req_player = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("rstp_left",  cards_left, 52);
      check("rstp_value", card_value, 0);
      check("rstp_busy",  busy, 0);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (gnt_player || gnt_dealer) bad++;
      end
      check("rstp_no_gnt", bad, 0);

      // shuffle while busy is not latched
      do_reset();
      req_player = 1'b1;
      @(negedge clk);
      shuffle = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("busy_shuf_gnt", gnt_player, 1);
      shuffle = 1'b0; req_player = 1'b0;
      check("busy_shuf_left", cards_left, 51);
      @(negedge clk);
      @(negedge clk);
      check("busy_shuf_idle", busy, 0);
      check("busy_shuf_keep", cards_left, 51);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/card_deck_arbiter.md
# card_deck_arbiter

Shared card source for the blackjack table. It owns a 52-card deck and draws pseudo-random, never-repeating cards. Two requesters compete for the deck: the player-hand controller and the dealer-hand controller. Grants use round-robin arbitration, and each grant returns one card (value, symbol) for the `card` renderers' value/symbol registers. The block sits between the game FSM and the hand registers that feed the card drawing chain.

## Interface
Parameters:
- LFSR_SEED, 16'hACE1, non-zero reset value of the draw LFSR.

Ports:
- clk  in  1  system clock, posedge active.
- rst  in  1  reset; synchronous, active-high. Clock is clk.
- shuffle  in  1  return all 52 cards to the deck; sampled in IDLE only.
- req_player  in  1  level draw request. Held until gnt_player, dropped the cycle after.
- req_dealer  in  1  level draw request. Same rules as req_player.
- gnt_player  out  1  one-cycle pulse; card_value/card_symbol valid for player.
- gnt_dealer  out  1  one-cycle pulse; card_value/card_symbol valid for dealer.
- card_value  out  4  1..13 (1=A, 11=J, 12=Q, 13=K); holds last drawn card.
- card_symbol  out  2  suit 0..3; holds last drawn card.
- cards_left  out  6  0..52 cards remaining.
- deck_empty  out  1  cards_left == 0.
- busy  out  1  state != IDLE.

## Operation
- Deck index idx 0..51: value = idx%13 + 1, symbol = idx/13. The used[51:0] mask marks dealt cards.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Free-running; advances every cycle except during rst.
- FSM states are IDLE, DRAW, PROBE, GRANT, CLEAR.
- IDLE:
  - If shuffle is asserted, go to CLEAR. Shuffle has priority over requests.
  - Else, if any request is asserted and deck_empty is 0:
    - Arbitrate. If only one request is asserted, it wins. If both are asserted, the requester other than last_winner wins.
    - Latch the winner in owner, set last_winner, go to DRAW.
  - Requests arriving while deck_empty=1 are ignored; stay in IDLE.
- DRAW: idx = lfsr[5:0], minus 52 if ≥52. Go to PROBE.
- PROBE:
  - If used[idx]=0: set used[idx], register card_value/card_symbol, decrement cards_left, go to GRANT.
  - Else: idx = (idx==51) ? 0 : idx+1, stay in PROBE. Linear probing guarantees a hit because cards_left>0 was checked.
- GRANT: assert gnt of owner for exactly this cycle, go to IDLE.
- CLEAR: used cleared to 0, cards_left = 52, go to IDLE. Card outputs are unchanged.
- shuffle asserted outside IDLE is not latched. The requester must hold it until busy=0.

## Timing
- Reset values:
  - state IDLE; used all 0; cards_left 52; deck_empty 0; busy 0.
  - gnt_player and gnt_dealer 0; card_value 0; card_symbol 0.
  - lfsr LFSR_SEED; last_winner = dealer, so player wins the first tie.
- Latency is measured from a request sampled in IDLE at cycle n:
  - DRAW at n+1, PROBE at n+2.
  - gnt high at n+3 minimum, n+54 maximum (51 probe misses).
- Grant rate is at most one grant per 4 cycles. Back-to-back requests from the same requester are re-arbitrated each time.
- card_value/card_symbol change at the cycle entering GRANT and are stable while gnt is high.
- Simultaneous req_player and req_dealer produce alternating grants: player, dealer, player, and so on.
- rst in any state returns to IDLE next cycle with all reset values. A pending grant is lost and the deck is full.
- cards_left arithmetic is 6-bit unsigned. It never decrements below 0, which the IDLE empty check guarantees.

## Structure
- blackjack_pkg holds:
  - DECK_SIZE = 52 and RANKS = 13.
  - typedef card_t (value 4 bits, symbol 2 bits).
  - the FSM state enum type (3 bits).
- Sub-module lfsr16: clk, rst, seed parameter, en input, q[15:0] output. This module instantiates it with en=1.
- Index-to-card mapping is combinational: a compare/subtract chain, no divider.

## Test plan
- Reset, then 52 single req_player draws:
  - 52 gnt_player pulses.
  - All 52 (value,symbol) pairs are distinct; every value is 1..13 and every symbol is 0..3.
  - cards_left=0, deck_empty=1 at the end.
  - A 53rd request: no grant in 100 cycles, busy stays 0.
- Hold req_player and req_dealer together for 6 grants:
  - Grant order is P, D, P, D, P, D.
  - cards_left decrements 52→46.
- Full deck, then shuffle=1 for one cycle in IDLE:
  - busy for 1 cycle, then cards_left=52 and deck_empty=0.
  - The next request is granted within 54 cycles.
- 51 cards drawn, then a request:
  - The single remaining card is granted.
  - Latency is between 3 and 54 cycles.
  - Its idx is the only one absent from the previous 51.
- rst asserted in PROBE (one cycle after DRAW):
  - No gnt follows.
  - Next cycle cards_left=52, card_value=0, busy=0.
- shuffle pulsed while busy=1: ignored, and cards_left still decrements after GRANT.
